// File: rtl/seq_detector_param.sv
// Channelised serial pattern detector: samples one of CH bit streams and matches a
// runtime-loaded pattern of 1..PAT_W bits, with overlap control and a saturating match count.
module seq_detector_param #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned CH    = 4,
    parameter int unsigned CNT_W = 8,
    localparam int unsigned SEL_W = (CH > 1) ? $clog2(CH) : 1,
    localparam int unsigned LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [CH-1:0]    seq_in,
    input  logic [SEL_W-1:0] ch_sel,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_value,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             det_out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StHunt = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic             pat_valid_q, pat_valid_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic             det_q, det_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    logic [SEL_W-1:0] sel_eff;
    logic             bit_in;
    logic [LEN_W-1:0] len_clamped;
    logic [PAT_W-1:0] mask;
    logic             match;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            hist_q      <= '0;
            pat_q       <= '0;
            len_q       <= LEN_W'(PAT_W);
            fill_q      <= '0;
            pat_valid_q <= 1'b0;
            ch_q        <= '0;
            det_q       <= 1'b0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            fill_q      <= fill_d;
            pat_valid_q <= pat_valid_d;
            ch_q        <= ch_d;
            det_q       <= det_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        pat_d       = pat_q;
        len_d       = len_q;
        fill_d      = fill_q;
        pat_valid_d = pat_valid_q;
        ch_d        = ch_q;
        det_d       = 1'b0;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        match       = 1'b0;

        // Out-of-range selects alias to channel 0.
        if ({1'b0, ch_sel} >= (SEL_W + 1)'(CH)) begin
            sel_eff = '0;
        end else begin
            sel_eff = ch_sel;
        end
        bit_in = seq_in[sel_eff];

        if (pat_len == '0 || pat_len > LEN_W'(PAT_W)) begin
            len_clamped = LEN_W'(PAT_W);
        end else begin
            len_clamped = pat_len;
        end

        for (int i = 0; i < int'(PAT_W); i++) begin
            mask[i] = (i < int'(len_q));
        end

        if (pat_load) begin
            pat_d       = pat_value;
            len_d       = len_clamped;
            pat_valid_d = 1'b1;
            hist_d      = '0;
            fill_d      = '0;
        end else if (en && pat_valid_q) begin
            if (ch_sel != ch_q) begin
                hist_d = {{(PAT_W - 1){1'b0}}, bit_in};
                fill_d = LEN_W'(1);
            end else begin
                hist_d = {hist_q[PAT_W-2:0], bit_in};
                fill_d = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + 1'b1;
            end
            match = (fill_d >= len_q) && ((hist_d & mask) == (pat_q & mask));
            if (match) begin
                det_d = 1'b1;
                // Non-overlapping mode demands len fresh bits for the next hit.
                if (!overlap) begin
                    fill_d = '0;
                end
            end
        end

        if (en) begin
            ch_d = ch_sel;
        end

        if (cnt_clr) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (match) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_d == '1) begin
                sat_d = 1'b1;
            end
        end

        if (!en || !pat_valid_d) begin
            state_d = StIdle;
        end else if (fill_d >= len_d) begin
            state_d = StHunt;
        end else begin
            state_d = StFill;
        end
    end

    assign det_out   = det_q;
    assign match_cnt = cnt_q;
    assign cnt_sat   = sat_q;
    assign state     = state_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: hand-computed pulse, count and state expectations.
module tb_seq_detector_param;

    localparam int PAT_W = 8;
    localparam int CH    = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [CH-1:0]    seq_in;
    logic [1:0]       ch_sel;
    logic             pat_load;
    logic [PAT_W-1:0] pat_value;
    logic [3:0]       pat_len;
    logic             overlap;
    logic             cnt_clr;
    logic             det_out;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;
    logic [1:0]       state;

    int checks = 0;
    int errors = 0;

    seq_detector_param #(
        .PAT_W(PAT_W),
        .CH   (CH),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .seq_in   (seq_in),
        .ch_sel   (ch_sel),
        .pat_load (pat_load),
        .pat_value(pat_value),
        .pat_len  (pat_len),
        .overlap  (overlap),
        .cnt_clr  (cnt_clr),
        .det_out  (det_out),
        .match_cnt(match_cnt),
        .cnt_sat  (cnt_sat),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive bit b on channel ch and its complement on the others, then sample.
    task automatic send(input int ch, input bit b, input bit exp_det, input int exp_state,
                        input string tag);
        ch_sel = 2'(ch);
        seq_in = b ? 4'(1 << ch) : ~4'(1 << ch);
        en     = 1'b1;
        tick();
        check_eq({tag, " det"}, 32'(det_out), 32'(exp_det));
        check_eq({tag, " state"}, 32'(state), 32'(exp_state));
    endtask

    task automatic send_seq(input int ch, input logic [15:0] bits, input int n,
                            input logic [15:0] dets, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            ch_sel = 2'(ch);
            seq_in = bits[i] ? 4'(1 << ch) : ~4'(1 << ch);
            en     = 1'b1;
            tick();
            check_eq($sformatf("%s bit%0d det", tag, n - i), 32'(det_out), 32'(dets[i]));
        end
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input bit clr,
                        input string tag);
        pat_value = pat;
        pat_len   = len;
        pat_load  = 1'b1;
        cnt_clr   = clr;
        en        = 1'b1;
        ch_sel    = 2'd0;
        seq_in    = '1;
        tick();
        pat_load  = 1'b0;
        cnt_clr   = 1'b0;
        check_eq({tag, " load det"}, 32'(det_out), 32'd0);
        check_eq({tag, " load state"}, 32'(state), 32'd1);
    endtask

    task automatic idle_tick(input string tag);
        en     = 1'b0;
        ch_sel = 2'd2;
        seq_in = 4'($urandom_range(0, 15));
        tick();
        check_eq({tag, " idle det"}, 32'(det_out), 32'd0);
        check_eq({tag, " idle state"}, 32'(state), 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        en        = 1'b0;
        seq_in    = '0;
        ch_sel    = '0;
        pat_load  = 1'b0;
        pat_value = '0;
        pat_len   = '0;
        overlap   = 1'b1;
        cnt_clr   = 1'b0;
        #2;
        check_eq("reset det", 32'(det_out), 32'd0);
        check_eq("reset cnt", 32'(match_cnt), 32'd0);
        check_eq("reset sat", 32'(cnt_sat), 32'd0);
        check_eq("reset state", 32'(state), 32'd0);
        tick();
        reset = 1'b1;

        // No pattern loaded: zero stream never detects, FSM stays idle.
        send(0, 1'b0, 1'b0, 0, "noload b1");
        send(0, 1'b0, 1'b0, 0, "noload b2");
        send(0, 1'b0, 1'b0, 0, "noload b3");

        // Overlapping 1011 on 1,0,1,1,0,1,1.
        overlap = 1'b1;
        load(8'b0000_1011, 4'd4, 1'b0, "t1");
        send_seq(0, 16'b101, 3, 16'b000, "t1");
        check_eq("t1 fill state", 32'(state), 32'd1);
        send(0, 1'b1, 1'b1, 2, "t1 b4");
        send_seq(0, 16'b011, 3, 16'b001, "t1 tail");
        check_eq("t1 cnt", 32'(match_cnt), 32'd2);

        // Non-overlapping, same stream; clear rides along with the load.
        overlap = 1'b0;
        load(8'b0000_1011, 4'd4, 1'b1, "t2");
        send_seq(0, 16'b101, 3, 16'b000, "t2");
        send(0, 1'b1, 1'b1, 1, "t2 b4");
        send_seq(0, 16'b011, 3, 16'b000, "t2 tail");
        check_eq("t2 cnt", 32'(match_cnt), 32'd1);

        load(8'b0000_1011, 4'd4, 1'b1, "t2b");
        send_seq(0, 16'b1011_1011, 8, 16'b0001_0001, "t2b");
        check_eq("t2b cnt", 32'(match_cnt), 32'd2);
        overlap = 1'b1;
        load(8'b0000_1011, 4'd4, 1'b1, "t2c");
        send_seq(0, 16'b1011_1011, 8, 16'b0001_0001, "t2c");
        check_eq("t2c cnt", 32'(match_cnt), 32'd2);

        // Channel switch flushes history.
        load(8'b0000_1011, 4'd4, 1'b1, "t3");
        send_seq(0, 16'b101, 3, 16'b000, "t3 ch0");
        send(1, 1'b1, 1'b0, 1, "t3 switch");
        send_seq(1, 16'b011, 3, 16'b001, "t3 ch1");
        check_eq("t3 state", 32'(state), 32'd2);
        check_eq("t3 cnt", 32'(match_cnt), 32'd1);

        // en=0 holds history and registered channel.
        load(8'b0000_1011, 4'd4, 1'b1, "t4");
        send_seq(0, 16'b10, 2, 16'b00, "t4 pre");
        idle_tick("t4 a");
        idle_tick("t4 b");
        send_seq(0, 16'b11, 2, 16'b01, "t4 post");

        // Reload mid-pattern discards the load-edge bit and flushes.
        load(8'b0000_1011, 4'd4, 1'b1, "t5");
        send_seq(0, 16'b101, 3, 16'b000, "t5 pre");
        load(8'b0000_1011, 4'd4, 1'b0, "t5 reload");
        send_seq(0, 16'b1011, 4, 16'b0001, "t5 post");
        check_eq("t5 cnt", 32'(match_cnt), 32'd1);

        // Saturation with a 3-bit counter: pattern 11, ten ones give nine matches.
        load(8'b0000_0011, 4'd2, 1'b1, "t6");
        send_seq(0, 16'h03FF, 10, 16'h01FF, "t6");
        check_eq("t6 cnt", 32'(match_cnt), 32'd7);
        check_eq("t6 sat", 32'(cnt_sat), 32'd1);
        cnt_clr = 1'b1;
        send(0, 1'b1, 1'b1, 2, "t6 clr+match");
        cnt_clr = 1'b0;
        check_eq("t6 clr cnt", 32'(match_cnt), 32'd0);
        check_eq("t6 clr sat", 32'(cnt_sat), 32'd0);
        send(0, 1'b1, 1'b1, 2, "t6 after clr");
        check_eq("t6 after cnt", 32'(match_cnt), 32'd1);

        // pat_len 0 latches as full width.
        load(8'hA5, 4'd0, 1'b1, "t7");
        send_seq(0, 16'b1010_0101, 8, 16'b0000_0001, "t7");
        check_eq("t7 state", 32'(state), 32'd2);
        check_eq("t7 cnt", 32'(match_cnt), 32'd1);

        // Asynchronous reset mid-cycle while the pulse is high.
        #3;
        reset = 1'b0;
        #1;
        check_eq("arst det", 32'(det_out), 32'd0);
        check_eq("arst cnt", 32'(match_cnt), 32'd0);
        check_eq("arst sat", 32'(cnt_sat), 32'd0);
        check_eq("arst state", 32'(state), 32'd0);
        #1;
        reset = 1'b1;
        send(0, 1'b1, 1'b0, 0, "arst noload");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
